// File: rtl/ant_pkg.sv
// Shared constants for the ant sprite overlay: bitmap, direction encoding, colour width.
package ant_pkg;

    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned BMP_SIZE = 8;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } ant_dir_e;

    // Up-facing ant, row 0 at the top; leftmost literal bit is x = 0.
    localparam logic [0:BMP_SIZE-1] ANT_BITMAP [BMP_SIZE] = '{
        8'b01000010,
        8'b00100100,
        8'b00011000,
        8'b10111101,
        8'b01011010,
        8'b00111100,
        8'b01011010,
        8'b10011001
    };

    // Ceiling log2 with a floor of one bit so single-entry ranges still get a port.
    function automatic int unsigned ant_clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/ant_sprite_mux_if.sv
// Pixel-stream, ant-configuration and overlay-output signals of ant_sprite_mux.
interface ant_sprite_mux_if
    import ant_pkg::*;
#(
    parameter int unsigned C_CELL_SIZE      = 8,
    parameter int unsigned C_NUM_OF_CELLS_X = 64,
    parameter int unsigned C_NUM_OF_CELLS_Y = 64,
    parameter int unsigned C_NUM_ANTS       = 4
);
    localparam int unsigned CX_W  = ant_clog2(C_NUM_OF_CELLS_X);
    localparam int unsigned CY_W  = ant_clog2(C_NUM_OF_CELLS_Y);
    localparam int unsigned OFS_W = ant_clog2(C_CELL_SIZE);

    logic                            ivalid;
    logic                            iframe;
    logic [CY_W-1:0]                 line;
    logic [CX_W-1:0]                 column;
    logic [OFS_W-1:0]                irx;
    logic [OFS_W-1:0]                iry;
    logic [C_NUM_ANTS*CX_W-1:0]      iant_pos_x;
    logic [C_NUM_ANTS*CY_W-1:0]      iant_pos_y;
    logic [2*C_NUM_ANTS-1:0]         iant_dir;
    logic [COLOR_W*C_NUM_ANTS-1:0]   iant_color;
    logic [C_NUM_ANTS-1:0]           iant_en;
    logic [C_NUM_ANTS-1:0]           iant_blink;
    logic                            odata_en;
    logic [COLOR_W-1:0]              odata;

    modport master (
        output ivalid, iframe, line, column, irx, iry,
        output iant_pos_x, iant_pos_y, iant_dir, iant_color, iant_en, iant_blink,
        input  odata_en, odata
    );

    modport slave (
        input  ivalid, iframe, line, column, irx, iry,
        input  iant_pos_x, iant_pos_y, iant_dir, iant_color, iant_en, iant_blink,
        output odata_en, odata
    );

endinterface

// File: rtl/ant_sprite_rom.sv
// Combinational sprite lookup: rotates the pixel offset into the up-facing bitmap frame.
module ant_sprite_rom
    import ant_pkg::*;
#(
    parameter int unsigned C_CELL_SIZE = 8,
    parameter int unsigned OFS_W       = 3
) (
    input  logic [OFS_W-1:0] rx,
    input  logic [OFS_W-1:0] ry,
    input  ant_dir_e         dir,
    output logic             pixel
);
    localparam logic [OFS_W-1:0] EDGE = OFS_W'(C_CELL_SIZE - 1);

    logic [OFS_W-1:0] sx;
    logic [OFS_W-1:0] sy;

    always_comb begin
        sx = rx;
        sy = ry;
        unique case (dir)
            DirUp:    begin sx = rx; sy = ry;        end
            DirDown:  begin sx = rx; sy = EDGE - ry; end
            DirLeft:  begin sx = ry; sy = rx;        end
            DirRight: begin sx = ry; sy = EDGE - rx; end
        endcase
    end

    // Cells larger than the stored bitmap show transparent pixels outside it.
    always_comb begin
        pixel = 1'b0;
        for (int y = 0; y < int'(BMP_SIZE); y++) begin
            for (int x = 0; x < int'(BMP_SIZE); x++) begin
                if (int'(sy) == y && int'(sx) == x) pixel = ANT_BITMAP[y][x];
            end
        end
    end

endmodule

// File: rtl/ant_sprite_mux.sv
// Ant sprite overlay: per-ant hit test, lowest-index priority, frame-synchronous blink.
// Two register stages: per-ant hits/colours, then the resolved pixel.
module ant_sprite_mux
    import ant_pkg::*;
#(
    parameter int unsigned C_CELL_SIZE      = 8,
    parameter int unsigned C_NUM_OF_CELLS_X = 64,
    parameter int unsigned C_NUM_OF_CELLS_Y = 64,
    parameter int unsigned C_NUM_ANTS       = 4,
    parameter int unsigned C_BLINK_FRAMES   = 16
) (
    input logic             iclk,
    input logic             irst,
    ant_sprite_mux_if.slave bus
);
    localparam int unsigned CX_W  = ant_clog2(C_NUM_OF_CELLS_X);
    localparam int unsigned CY_W  = ant_clog2(C_NUM_OF_CELLS_Y);
    localparam int unsigned OFS_W = ant_clog2(C_CELL_SIZE);
    localparam int unsigned FRM_W = ant_clog2(C_BLINK_FRAMES);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(C_BLINK_FRAMES - 1);

    logic [FRM_W-1:0]              frame_cnt_q;
    logic                          blink_phase_q;
    logic                          in_range;
    logic [C_NUM_ANTS-1:0]         pix;
    logic [C_NUM_ANTS-1:0]         hit_d;
    logic [C_NUM_ANTS-1:0]         hit_q;
    logic [C_NUM_ANTS*COLOR_W-1:0] color_q;
    logic                          data_en_d;
    logic                          data_en_q;
    logic [COLOR_W-1:0]            data_d;
    logic [COLOR_W-1:0]            data_q;

    always_ff @(posedge iclk) begin
        if (irst) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (bus.iframe) begin
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    // Only matters for non power-of-two grids/cells where the coordinate ports can overrun.
    assign in_range = (32'(bus.column) < C_NUM_OF_CELLS_X) &&
                      (32'(bus.line)   < C_NUM_OF_CELLS_Y) &&
                      (32'(bus.irx)    < C_CELL_SIZE) &&
                      (32'(bus.iry)    < C_CELL_SIZE);

    for (genvar k = 0; k < C_NUM_ANTS; k++) begin : g_ant
        logic [CX_W-1:0] pos_x;
        logic [CY_W-1:0] pos_y;

        assign pos_x = bus.iant_pos_x[k*CX_W +: CX_W];
        assign pos_y = bus.iant_pos_y[k*CY_W +: CY_W];

        ant_sprite_rom #(
            .C_CELL_SIZE (C_CELL_SIZE),
            .OFS_W       (OFS_W)
        ) u_rom (
            .rx    (bus.irx),
            .ry    (bus.iry),
            .dir   (ant_dir_e'(bus.iant_dir[2*k +: 2])),
            .pixel (pix[k])
        );

        assign hit_d[k] = bus.ivalid && in_range && bus.iant_en[k] &&
                          (pos_x == bus.column) && (pos_y == bus.line) && pix[k] &&
                          !(bus.iant_blink[k] && blink_phase_q);
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            hit_q   <= '0;
            color_q <= '0;
        end else begin
            hit_q   <= hit_d;
            color_q <= bus.iant_color;
        end
    end

    // Walk from the top index down so the lowest-index hit is written last and wins.
    always_comb begin
        data_en_d = 1'b0;
        data_d    = '0;
        for (int k = int'(C_NUM_ANTS) - 1; k >= 0; k--) begin
            if (hit_q[k]) begin
                data_en_d = 1'b1;
                data_d    = color_q[k*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            data_en_q <= 1'b0;
            data_q    <= '0;
        end else begin
            data_en_q <= data_en_d;
            data_q    <= data_d;
        end
    end

    assign bus.odata_en = data_en_q;
    assign bus.odata    = data_q;

endmodule

// File: tb/tb_ant_sprite_mux.sv
// Self-checking bench for ant_sprite_mux: directed pixels, a cycle-by-cycle reference model
// and hand-computed literal expectations.
module tb_ant_sprite_mux;
    localparam int S  = 8;
    localparam int NX = 64;
    localparam int NY = 64;
    localparam int NA = 4;
    localparam int NB = 2;
    localparam int CW = 6;
    localparam int OW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ant_sprite_mux_if #(
        .C_CELL_SIZE      (S),
        .C_NUM_OF_CELLS_X (NX),
        .C_NUM_OF_CELLS_Y (NY),
        .C_NUM_ANTS       (NA)
    ) bus ();

    ant_sprite_mux #(
        .C_CELL_SIZE      (S),
        .C_NUM_OF_CELLS_X (NX),
        .C_NUM_OF_CELLS_Y (NY),
        .C_NUM_ANTS       (NA),
        .C_BLINK_FRAMES   (NB)
    ) dut (
        .iclk (clk),
        .irst (rst),
        .bus  (bus)
    );

    logic       valid = 1'b0;
    logic       frame = 1'b0;
    int         cur_col = 0, cur_line = 0, cur_rx = 0, cur_ry = 0;
    int         ant_x [NA];
    int         ant_y [NA];
    int         ant_dir [NA];
    logic [2:0] ant_color [NA];
    logic       ant_en [NA];
    logic       ant_blk [NA];

    always_comb begin
        bus.ivalid     = valid;
        bus.iframe     = frame;
        bus.column     = CW'(cur_col);
        bus.line       = CW'(cur_line);
        bus.irx        = OW'(cur_rx);
        bus.iry        = OW'(cur_ry);
        bus.iant_pos_x = '0;
        bus.iant_pos_y = '0;
        bus.iant_dir   = '0;
        bus.iant_color = '0;
        bus.iant_en    = '0;
        bus.iant_blink = '0;
        for (int k = 0; k < NA; k++) begin
            bus.iant_pos_x[k*CW +: CW] = CW'(ant_x[k]);
            bus.iant_pos_y[k*CW +: CW] = CW'(ant_y[k]);
            bus.iant_dir[k*2 +: 2]     = 2'(ant_dir[k]);
            bus.iant_color[k*3 +: 3]   = ant_color[k];
            bus.iant_en[k]             = ant_en[k];
            bus.iant_blink[k]          = ant_blk[k];
        end
    end

    // Reference sprite, row 0 first, leftmost bit is x = 0.
    logic [63:0] bmp = {8'b01000010, 8'b00100100, 8'b00011000, 8'b10111101,
                        8'b01011010, 8'b00111100, 8'b01011010, 8'b10011001};

    function automatic logic bmp_at(input int x, input int y);
        return bmp[63 - (y * 8 + x)];
    endfunction

    // {present, rgb} for the pixel currently on the inputs, given frames seen since reset.
    function automatic logic [3:0] expect_now(input int frames);
        logic hidden;
        int   sx, sy;
        hidden = ((frames / NB) % 2) == 1;
        if (!valid || cur_rx >= S || cur_ry >= S) return 4'b0000;
        for (int k = 0; k < NA; k++) begin
            if (!ant_en[k] || ant_x[k] != cur_col || ant_y[k] != cur_line) continue;
            if (ant_blk[k] && hidden) continue;
            case (ant_dir[k])
                0:       begin sx = cur_rx; sy = cur_ry;         end
                1:       begin sx = cur_rx; sy = S - 1 - cur_ry; end
                2:       begin sx = cur_ry; sy = cur_rx;         end
                default: begin sx = cur_ry; sy = S - 1 - cur_rx; end
            endcase
            if (bmp_at(sx, sy)) return {1'b1, ant_color[k]};
        end
        return 4'b0000;
    endfunction

    int         frames_seen = 0;
    logic [3:0] exp1 = 4'b0000;
    logic [3:0] exp2 = 4'b0000;

    always @(posedge clk) begin
        if (rst) begin
            exp1        <= 4'b0000;
            exp2        <= 4'b0000;
            frames_seen <= 0;
        end else begin
            exp1 <= expect_now(frames_seen);
            exp2 <= exp1;
            if (frame) frames_seen <= frames_seen + 1;
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         hit_count = 0;
    logic       chk_on = 1'b0;
    logic       lit_req = 1'b0;
    int         lit_kind = 0;
    string      lit_name = "";
    logic [3:0] lit_want = 4'b0000;
    int         lit_want_cnt = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if ({bus.odata_en, bus.odata} !== exp2) begin
                errors++;
                $display("FAIL model t=%0t: got en=%0b data=%03b, want en=%0b data=%03b",
                         $time, bus.odata_en, bus.odata, exp2[3], exp2[2:0]);
            end
            if (bus.odata_en === 1'b1) hit_count++;
            if (lit_req) begin
                checks++;
                if (lit_kind == 0 && {bus.odata_en, bus.odata} !== lit_want) begin
                    errors++;
                    $display("FAIL %s: got en=%0b data=%03b, want en=%0b data=%03b", lit_name,
                             bus.odata_en, bus.odata, lit_want[3], lit_want[2:0]);
                end else if (lit_kind == 1 && hit_count != lit_want_cnt) begin
                    errors++;
                    $display("FAIL %s: got hits=%0d, want hits=%0d", lit_name, hit_count,
                             lit_want_cnt);
                end
            end
        end
    end

    task automatic set_pixel(input int col, input int ln, input int rx, input int ry,
                             input logic v);
        cur_col = col; cur_line = ln; cur_rx = rx; cur_ry = ry; valid = v;
    endtask

    task automatic expect_px(input string name, input logic [3:0] want);
        lit_name = name; lit_kind = 0; lit_want = want; lit_req = 1'b1;
        @(negedge clk); #1;
        lit_req = 1'b0;
    endtask

    task automatic expect_cnt(input string name, input int want);
        lit_name = name; lit_kind = 1; lit_want_cnt = want; lit_req = 1'b1;
        @(negedge clk); #1;
        lit_req = 1'b0;
    endtask

    task automatic probe(input string name, input int col, input int ln, input int rx,
                         input int ry, input logic [3:0] want);
        set_pixel(col, ln, rx, ry, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        expect_px(name, want);
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        @(posedge clk); #1;
        frame = 1'b0;
        @(posedge clk); #1;
    endtask

    // Streams every pixel of cell (3,5) once; returns the hit count before the sweep.
    task automatic sweep_cell(output int base);
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = hit_count;
        for (int y = 0; y < S; y++) begin
            for (int x = 0; x < S; x++) begin
                set_pixel(3, 5, x, y, 1'b1);
                @(posedge clk); #1;
            end
        end
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        for (int k = 0; k < NA; k++) begin
            ant_x[k] = 0; ant_y[k] = 0; ant_dir[k] = 0;
            ant_color[k] = 3'b000; ant_en[k] = 1'b0; ant_blk[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        expect_px("reset_idle", 4'b0000);
        rst = 1'b0;

        ant_x[0] = 3; ant_y[0] = 5; ant_dir[0] = 0; ant_color[0] = 3'b001; ant_en[0] = 1'b1;
        probe("up_hit", 3, 5, 4, 2, 4'b1001);
        probe("up_transparent", 3, 5, 0, 0, 4'b0000);
        probe("wrong_cell", 4, 5, 4, 2, 4'b0000);
        set_pixel(3, 5, 4, 2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        expect_px("not_valid", 4'b0000);

        ant_dir[0] = 2; ant_color[0] = 3'b100;
        ant_x[1] = 3; ant_y[1] = 5; ant_dir[1] = 0; ant_color[1] = 3'b010; ant_en[1] = 1'b1;
        probe("overlap_both", 3, 5, 3, 3, 4'b1100);
        probe("overlap_ant1_only", 3, 5, 4, 2, 4'b1010);
        probe("overlap_ant0_only", 3, 5, 2, 4, 4'b1100);

        ant_en[1] = 1'b0; ant_color[0] = 3'b001;
        ant_dir[0] = 1;
        probe("down_hit", 3, 5, 4, 5, 4'b1001);
        probe("down_transparent", 3, 5, 0, 7, 4'b0000);
        ant_dir[0] = 3;
        probe("right_hit", 3, 5, 5, 3, 4'b1001);
        probe("right_transparent", 3, 5, 2, 0, 4'b0000);

        for (int d = 0; d < 4; d++) begin
            ant_dir[0] = d;
            sweep_cell(base);
            expect_cnt($sformatf("sweep_dir%0d", d), base + 28);
        end
        ant_en[0] = 1'b0;
        sweep_cell(base);
        expect_cnt("disabled_sweep", base);

        ant_en[0] = 1'b1; ant_dir[0] = 0; ant_blk[0] = 1'b1;
        ant_x[1] = 4; ant_y[1] = 5; ant_dir[1] = 0; ant_en[1] = 1'b1; ant_blk[1] = 1'b0;
        probe("blink_phase0", 3, 5, 4, 2, 4'b1001);
        pulse_frame();
        pulse_frame();
        probe("blink_hidden", 3, 5, 4, 2, 4'b0000);
        probe("nonblink_visible", 4, 5, 4, 2, 4'b1010);
        set_pixel(3, 5, 4, 2, 1'b1);
        pulse_frame();
        pulse_frame();
        probe("blink_back", 3, 5, 4, 2, 4'b1001);

        pulse_frame();
        pulse_frame();
        pulse_frame();
        probe("pre_reset_hidden", 3, 5, 4, 2, 4'b0000);
        rst = 1'b1; frame = 1'b1;
        @(posedge clk); #1;
        expect_px("reset_midline", 4'b0000);
        rst = 1'b0; frame = 1'b0;
        probe("reset_phase0", 3, 5, 4, 2, 4'b1001);
        pulse_frame();
        probe("reset_one_frame", 3, 5, 4, 2, 4'b1001);
        pulse_frame();
        probe("reset_two_frames", 3, 5, 4, 2, 4'b0000);

        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ant_sprite_mux.md
ANT_SPRITE_MUX -- requirements
Module: ant_sprite_mux

Interface
REQ-001 Parameter C_CELL_SIZE, default 8, meaning sprite/cell edge in pixels (cells are square).
REQ-002 Parameter C_NUM_OF_CELLS_X, default 64, meaning grid columns.
REQ-003 Parameter C_NUM_OF_CELLS_Y, default 64, meaning grid lines.
REQ-004 Parameter C_NUM_ANTS, default 4, meaning number of ant channels (1..16).
REQ-005 Parameter C_BLINK_FRAMES, default 16, meaning frames per blink half-period (>=1).
REQ-006 Clock and reset SHALL be: one clock; reset is synchronous and active-high (iclk, irst).
REQ-007 iclk  in  1  pixel clock.
REQ-008 irst  in  1  synchronous active-high reset.
REQ-009 ivalid  in  1  current pixel coordinates valid.
REQ-010 iframe  in  1  one-cycle start-of-frame pulse.
REQ-011 line / column  in  clog2(cells) each  cell coordinate of current pixel.
REQ-012 irx / iry  in  clog2(C_CELL_SIZE) each  pixel offset inside cell.
REQ-013 iant_pos_x / iant_pos_y  in  C_NUM_ANTS*clog2(cells)  packed ant positions, ant 0 in LSBs.
REQ-014 iant_dir  in  2*C_NUM_ANTS  packed direction (0 up, 1 down, 2 left, 3 right).
REQ-015 iant_color  in  3*C_NUM_ANTS  packed RGB colour per ant.
REQ-016 iant_en / iant_blink  in  C_NUM_ANTS each  ant enable mask / ant blink mask.
REQ-017 odata_en  out  1  ant pixel present.
REQ-018 odata  out  3  ant pixel colour.

Function
REQ-019 Single up-facing bitmap SHALL be stored once; other directions derived by coordinate transform: up (sx=irx, sy=iry); down (irx, S-1-iry); left (iry, irx); right (iry, S-1-irx), S=C_CELL_SIZE.
REQ-020 Ant k SHALL hit when ivalid, iant_en[k], pos_x[k]==column, pos_y[k]==line, bitmap[sy][sx]==1, and not (iant_blink[k] and blink phase==1).
REQ-021 Pipeline: stage 1 registers per-ant hit bits and colours; stage 2 registers priority-resolved odata_en/odata; latency exactly 2 cycles from inputs, throughput 1 pixel/cycle.
REQ-022 Overlap: lowest-index ant with a hit SHALL win per pixel; lower ant's transparent pixels SHALL let higher ants show.
REQ-023 No hit: odata_en=0 and odata=3'b000.
REQ-024 Frame counter SHALL increment on iframe; at C_BLINK_FRAMES-1 plus iframe it wraps to 0 and blink phase toggles; C_BLINK_FRAMES=1 toggles every frame.
REQ-025 Blink phase change SHALL take effect for pixels entering stage 1 the cycle after the iframe pulse.
REQ-026 Ant positions outside grid, or irx/iry >= C_CELL_SIZE, SHALL never hit.
REQ-027 Position/direction/mask inputs SHALL be sampled per pixel with no internal holding; changes mid-frame take effect at the next pixel (2-cycle latency).

Reset
REQ-028 While irst=1: odata_en=0, odata=0, stage-1 hits cleared, frame counter=0, blink phase=0.
REQ-029 irst SHALL override simultaneous iframe; first valid output appears 2 cycles after irst deasserts with ivalid=1.

Structure
REQ-030 Package ant_pkg SHALL hold the bitmap constant, direction encoding constants, colour width and a clog2 helper.
REQ-031 Sub-module ant_sprite_rom (orientation transform + bitmap lookup, combinational) SHALL be instantiated once per ant.

Verification
REQ-032 Ant 0 at (3,5) dir up, col 3/line 5, irx=4 iry=2 -> odata_en=1 two cycles later; irx=0 iry=0 -> 0.
REQ-033 Same cell, ant0 dir left (red 3'b100), ant1 dir up (green 3'b010): pixel in both sprites -> 3'b100; pixel only in ant1 -> 3'b010.
REQ-034 C_BLINK_FRAMES=2, iant_blink[0]=1: pulse iframe twice -> ant 0 hidden; two more -> visible; non-blinking ant 1 always visible.
REQ-035 Each of 4 directions: full S x S sweep -> output map equals transformed bitmap exactly.
REQ-036 irst asserted mid-line with iframe high -> outputs 0 next cycle, counter 0, phase 0; iant_en=0 -> never odata_en.
